// File: rtl/dmem_responder.sv
// Data-memory responder for the pipelined core's DM_* port: doubleword stores, fixed-latency
// loads with a valid strobe, and a registered illegal-access flag. Option macro: DMEM_CLEAR_EN.
module dmem_responder #(
  parameter int N      = 64,
  parameter int DEPTH  = 64,
  parameter int RD_LAT = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] DM_addr,
  input  logic [N-1:0] DM_writeData,
  input  logic         DM_writeEnable,
  input  logic         DM_readEnable,
  output logic [N-1:0] DM_readData,
  output logic         DM_readValid,
  output logic         DM_addrError
);

  localparam int IW = $clog2(DEPTH);

  generate
    if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_lat
      $error("dmem_responder: RD_LAT must be in 1..4");
    end
    if (DEPTH < 2 || (1 << IW) != DEPTH) begin : g_bad_depth
      $error("dmem_responder: DEPTH must be a power of 2 and >= 2");
    end
  endgenerate

  logic [N-1:0]      mem [DEPTH];
  logic [IW-1:0]     idx;
  logic              legal;
  logic              do_wr;
  logic              access;
  logic [N-1:0]      ld_data;
  logic [RD_LAT-1:0] pipe_valid;
  logic [N-1:0]      pipe_data [RD_LAT];
  logic              addr_error;

  // Upper bits above the index must be zero: out-of-range addresses are rejected, never aliased.
  assign idx    = DM_addr[IW+2:3];
  assign legal  = (DM_addr[2:0] == 3'b000) && (DM_addr[N-1:IW+3] == '0);
  assign do_wr  = DM_writeEnable && legal;
  assign access = DM_writeEnable || DM_readEnable;

  // Write-first: a load and a store in the same cycle share one address, so the load sees the store.
  always_comb begin
    // NOTE: assign the default first so every path drives ld_data and no latch is inferred.
    ld_data = '0;
    if (legal) begin
      ld_data = DM_writeEnable ? DM_writeData : mem[idx];
    end
  end

  // NOTE: the array only gets a reset when the clear option is built in; without it the
  // storage stays reset-free so it can map onto a plain RAM macro.
`ifdef DMEM_CLEAR_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (do_wr) begin
      mem[idx] <= DM_writeData;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[idx] <= DM_writeData;
    end
  end
`endif

  // Read pipe: data stages only load when a valid word arrives, so the output holds between loads.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_error <= 1'b0;
      pipe_valid <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_data[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking so each stage samples its predecessor's value from before the edge.
      addr_error    <= access && !legal;
      pipe_valid[0] <= DM_readEnable;
      if (DM_readEnable) begin
        pipe_data[0] <= ld_data;
      end
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        if (pipe_valid[i-1]) begin
          pipe_data[i] <= pipe_data[i-1];
        end
      end
    end
  end

  assign DM_readData  = pipe_data[RD_LAT-1];
  assign DM_readValid = pipe_valid[RD_LAT-1];
  assign DM_addrError = addr_error;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: loads push expected data and due cycle, outputs are
// checked every cycle against the queue head. Honours DMEM_CLEAR_EN for post-reset contents.
module tb_dmem_responder;

  localparam int N      = 64;
  localparam int DEPTH  = 64;
  localparam int RD_LAT = 3;

  typedef struct {
    logic [N-1:0] data;
    int           due;
  } exp_t;

  logic         clk;
  logic         reset;
  logic [N-1:0] DM_addr;
  logic [N-1:0] DM_writeData;
  logic         DM_writeEnable;
  logic         DM_readEnable;
  logic [N-1:0] DM_readData;
  logic         DM_readValid;
  logic         DM_addrError;

  dmem_responder #(.N(N), .DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
    .clk            (clk),
    .reset          (reset),
    .DM_addr        (DM_addr),
    .DM_writeData   (DM_writeData),
    .DM_writeEnable (DM_writeEnable),
    .DM_readEnable  (DM_readEnable),
    .DM_readData    (DM_readData),
    .DM_readValid   (DM_readValid),
    .DM_addrError   (DM_addrError)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t         sb [$];
  logic [N-1:0] model [DEPTH];
  logic [N-1:0] last_data;
  int           cyc;
  int           n_tests;
  int           n_fail;

  task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h expected 0x%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic bit is_legal(input logic [N-1:0] a);
    return (a % 8 == 0) && (a < DEPTH * 8);
  endfunction

  // Drive one request cycle, advance one clock, then check error flag and read port.
  task automatic step(input logic we, input logic re, input logic [N-1:0] a, input logic [N-1:0] wd);
    logic         exp_err;
    logic [N-1:0] exp_ld;
    int           w;
    exp_t         e;
    DM_addr        = a;
    DM_writeData   = wd;
    DM_writeEnable = we;
    DM_readEnable  = re;
    w       = int'(a / 8) % DEPTH;
    exp_err = (we || re) && !is_legal(a);
    exp_ld  = '0;
    if (is_legal(a)) exp_ld = we ? wd : model[w];
    if (re) begin
      e.data = exp_ld;
      e.due  = cyc + RD_LAT;
      sb.push_back(e);
    end
    if (we && is_legal(a)) model[w] = wd;
    @(posedge clk);
    #1;
    cyc++;
    check("addr_error", {63'b0, DM_addrError}, {63'b0, exp_err});
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      check("read_valid", {63'b0, DM_readValid}, 64'd1);
      check("read_data", DM_readData, e.data);
      last_data = e.data;
    end else begin
      check("read_valid_idle", {63'b0, DM_readValid}, 64'd0);
      check("read_data_hold", DM_readData, last_data);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0);
  endtask

  // Assert reset part-way through a cycle, keep it across one rising edge, then release.
  task automatic pulse_reset();
    DM_writeEnable = 1'b0;
    DM_readEnable  = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check("rst_valid", {63'b0, DM_readValid}, 64'd0);
    check("rst_data", DM_readData, 64'd0);
    check("rst_err", {63'b0, DM_addrError}, 64'd0);
    @(posedge clk);
    #1;
    cyc++;
    check("rst_valid_edge", {63'b0, DM_readValid}, 64'd0);
    reset = 1'b1;
    sb.delete();
    last_data = '0;
`ifdef DMEM_CLEAR_EN
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
`endif
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    cyc     = 0;
    last_data      = '0;
    reset          = 1'b0;
    DM_addr        = '0;
    DM_writeData   = '0;
    DM_writeEnable = 1'b0;
    DM_readEnable  = 1'b0;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;

    #12;
    check("por_valid", {63'b0, DM_readValid}, 64'd0);
    check("por_data", DM_readData, 64'd0);
    check("por_err", {63'b0, DM_addrError}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    cyc++;

    // Give every word a known value so no load ever reads uninitialised storage.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, N'(i * 8), N'(64'h1000 + i));

    // Store then load the same word.
    step(1'b1, 1'b0, 64'h10, 64'hDEAD_BEEF_0000_0001);
    step(1'b0, 1'b1, 64'h10, '0);
    idle(RD_LAT + 1);

    // Back-to-back loads return back-to-back and in order.
    step(1'b1, 1'b0, 64'h00, 64'd1);
    step(1'b1, 1'b0, 64'h08, 64'd2);
    step(1'b1, 1'b0, 64'h10, 64'd3);
    step(1'b0, 1'b1, 64'h00, '0);
    step(1'b0, 1'b1, 64'h08, '0);
    step(1'b0, 1'b1, 64'h10, '0);
    idle(RD_LAT + 1);

    // Write-first, misaligned load, out-of-range store and load, no aliasing onto word 0.
    step(1'b1, 1'b1, 64'h18, 64'h55);
    step(1'b0, 1'b1, 64'h1C, '0);
    step(1'b1, 1'b0, N'(DEPTH * 8), 64'h99);
    step(1'b0, 1'b1, N'(DEPTH * 8), '0);
    step(1'b1, 1'b0, 64'h8000_0000_0000_0008, 64'h77);
    step(1'b0, 1'b1, 64'h00, '0);
    step(1'b0, 1'b1, 64'h08, '0);
    step(1'b0, 1'b1, 64'h18, '0);
    idle(RD_LAT + 1);

    // Reset with a load in flight: it must never be returned.
    step(1'b0, 1'b1, 64'h08, '0);
    pulse_reset();
    idle(RD_LAT + 2);

    // Contents across reset depend on the clear option.
    step(1'b1, 1'b0, 64'h20, 64'hAA);
    pulse_reset();
    step(1'b0, 1'b1, 64'h20, '0);
    idle(RD_LAT + 1);
`ifdef DMEM_CLEAR_EN
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, N'(i * 8), N'(64'h2000 + i));
`endif

    // A store after a captured load leaves that load's data alone.
    step(1'b1, 1'b0, 64'h28, 64'h11);
    step(1'b0, 1'b1, 64'h28, '0);
    step(1'b1, 1'b0, 64'h28, 64'h22);
    step(1'b0, 1'b1, 64'h28, '0);
    idle(RD_LAT + 1);

    // Random mix of loads, stores, idles and illegal addresses.
    for (int i = 0; i < 300; i++) begin
      logic [N-1:0] a;
      int           k;
      k = $urandom_range(0, 9);
      a = N'($urandom_range(0, DEPTH - 1) * 8);
      if (k == 0) a = a | N'($urandom_range(1, 7));
      if (k == 1) a = a + N'(DEPTH * 8 * $urandom_range(1, 4));
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, {$urandom, $urandom});
    end
    idle(RD_LAT + 1);
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
